// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM state encoding and operand-invert decode for the serial ALU
package alu_pkg;
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_ADDN = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Subtract-style ops invert B and start with carry 1 (two's complement)
    function automatic logic binvert(input logic [2:0] op);
        return op == OP_SUB || op == OP_SLT;
    endfunction
endpackage

// File: rtl/alu_serial_seq_if.sv
// alu_serial_seq_if: request/response handshake bundle between issue, serial ALU and writeback
interface alu_serial_seq_if #(parameter int W = 8);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         carry_out;

    modport master(output in_valid, a, b, op, out_ready,
                   input  in_ready, out_valid, result, zero, overflow, carry_out);
    modport slave (input  in_valid, a, b, op, out_ready,
                   output in_ready, out_valid, result, zero, overflow, carry_out);
endinterface

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: combinational 1-bit ALU slice; carry chain is always computed, even for logic ops
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       binvert,
    input  logic       carry_in,
    input  logic [2:0] operation,
    input  logic       less,
    output logic       result,
    output logic       carry_out,
    output logic       sum
);
    logic bb;

    assign bb        = b ^ binvert;
    assign sum       = a ^ bb ^ carry_in;
    assign carry_out = (a & bb) | (carry_in & (a ^ bb));

    always_comb begin
        result = sum;
        case (operation)
            OP_AND:  result = a & bb;
            OP_OR:   result = a | bb;
            OP_NAND: result = ~(a & bb);
            OP_NOR:  result = ~(a | bb);
            OP_SLT:  result = less;
            default: result = sum;
        endcase
    end
endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial ALU sequencer, one bit per cycle LSB first through a single slice
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input logic            clk,
    input logic            rst_n,
    alu_serial_seq_if.slave bus
);
    localparam int CW = $clog2(W);

    state_t        state, nstate;
    logic [CW-1:0] cnt;
    logic          carry;
    logic [W-1:0]  ra, rb, res, nres;
    logic [2:0]    rop;
    logic          zero_r, ovf_r, cout_r;
    logic          s_res, s_cout, s_sum, last;

    assign last = cnt == CW'(W - 1);

    alu_bit_slice u_slice (
        .a         (ra[cnt]),
        .b         (rb[cnt]),
        .binvert   (binvert(rop)),
        .carry_in  (carry),
        .operation (rop),
        .less      (1'b0),
        .result    (s_res),
        .carry_out (s_cout),
        .sum       (s_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = bus.in_valid ? RUN : IDLE;
            RUN:     nstate = last ? DONE : RUN;
            DONE:    nstate = bus.out_ready ? IDLE : DONE;
            default: nstate = IDLE;
        endcase
    end

    // SLT bit 0 is stored as 0 while running and replaced by the MSB sum on the last bit
    always_comb begin
        nres      = res;
        nres[cnt] = s_res;
        if (last && rop == OP_SLT) nres = {{(W-1){1'b0}}, s_sum};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            carry  <= 1'b0;
            ra     <= '0;
            rb     <= '0;
            rop    <= OP_AND;
            res    <= '0;
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
            cout_r <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            ra    <= bus.a;
            rb    <= bus.b;
            rop   <= bus.op;
            carry <= binvert(bus.op);
            cnt   <= '0;
        end else if (state == RUN) begin
            res   <= nres;
            carry <= s_cout;
            cnt   <= cnt + 1'b1;
            if (last) begin
                zero_r <= nres == '0;
                cout_r <= s_cout;
                ovf_r  <= (rop == OP_ADD || rop == OP_SUB) && (carry ^ s_cout);
            end
        end
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.result    = res;
    assign bus.zero      = zero_r;
    assign bus.overflow  = ovf_r;
    assign bus.carry_out = cout_r;
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: scoreboard bench for the serial ALU with word-level reference model
module tb_alu_serial_seq;
    typedef struct packed {
        logic [7:0] r;
        logic       z;
        logic       v;
        logic       c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_serial_seq_if #(.W(8)) bus();
    alu_serial_seq #(.W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        exp_t       e;
        logic       sub;
        logic [7:0] bb;
        logic [8:0] s;
        sub = op == 3'b110 || op == 3'b111;
        bb  = sub ? ~b : b;
        s   = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
        case (op)
            3'b000:  e.r = a & b;
            3'b001:  e.r = a | b;
            3'b011:  e.r = ~(a & b);
            3'b100:  e.r = ~(a | b);
            3'b111:  e.r = {7'd0, s[7]};
            default: e.r = s[7:0];
        endcase
        e.c = s[8];
        e.v = (op == 3'b010 || op == 3'b110) && (a[7] == bb[7]) && (s[7] != a[7]);
        e.z = e.r == 8'd0;
        return e;
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        exp_t e;
        int   cyc;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
        q.push_back(model(a, b, op));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("latency", cyc, 8);
        if (bus.out_valid) begin
            e = q.pop_front();
            chk("result", {24'd0, bus.result}, {24'd0, e.r});
            chk("zero", {31'd0, bus.zero}, {31'd0, e.z});
            chk("overflow", {31'd0, bus.overflow}, {31'd0, e.v});
            chk("carry_out", {31'd0, bus.carry_out}, {31'd0, e.c});
        end
    endtask

    task automatic release_out;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk("idle_valid", {31'd0, bus.out_valid}, 0);
        chk("idle_ready", {31'd0, bus.in_ready}, 1);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_ready"}, {31'd0, bus.in_ready}, 1);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 0);
        chk({tag, "_flags"}, {29'd0, bus.zero, bus.overflow, bus.carry_out}, 0);
        chk({tag, "_result"}, {24'd0, bus.result}, 0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.op = '0;
        repeat (2) @(posedge clk);
        #1 check_cleared("reset");
        @(negedge clk) rst_n = 1'b1;

        run_op(8'h7F, 8'h01, 3'b010); release_out();
        run_op(8'h05, 8'h05, 3'b110); release_out();
        run_op(8'h03, 8'h05, 3'b111); release_out();
        run_op(8'h80, 8'h01, 3'b111); release_out();
        run_op(8'h0F, 8'hF0, 3'b100); release_out();
        run_op(8'hFF, 8'hFF, 3'b011); release_out();
        run_op(8'h7F, 8'h01, 3'b101); release_out();
        run_op(8'hC3, 8'h5A, 3'b000); release_out();
        run_op(8'hC3, 8'h5A, 3'b001); release_out();
        run_op(8'h80, 8'h80, 3'b010); release_out();
        for (int i = 0; i < 12; i++) begin
            run_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
            release_out();
        end

        run_op(8'h12, 8'h34, 3'b010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.a = 8'hFF; bus.b = 8'hFF; bus.op = 3'b000; bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_result", {24'd0, bus.result}, 32'h46);
            chk("hold_valid", {31'd0, bus.out_valid}, 1);
            chk("hold_ready", {31'd0, bus.in_ready}, 0);
        end
        @(negedge clk) bus.in_valid = 1'b0;
        release_out();
        repeat (12) @(posedge clk);
        #1 chk("no_second_req", {31'd0, bus.out_valid}, 0);

        @(negedge clk);
        bus.a = 8'h7F; bus.b = 8'h01; bus.op = 3'b010; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1 check_cleared("midrst");
        @(negedge clk) rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 check_cleared("post_rst");

        run_op(8'h01, 8'h02, 3'b110); release_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
